// File: rtl/sonic_rx_ring_ctl.sv
// sonic_rx_ring_ctl
//   Single-clock RX ring buffer controller for the SONIC receive path.
//   The gearbox appends DATA_WIDTH-bit blocks in order; the DMA engine reads
//   any slot by address and releases slots oldest-first with rdreq.
//   Occupancy and status flags are tracked here. Writes into a full ring are
//   dropped and counted, and releases from an empty ring are counted as
//   underruns.
//
// Ports
//   clock, reset_n          sole clock, asynchronous active-low reset
//   data_in                 block from gearbox
//   wrena, wrreq            write enable / write request
//   rd_address              DMA random-read slot
//   rdena, rdreq            release enable / release oldest slot
//   clear_cnt               synchronous clear of counters and overflow
//   data_out                mem[rd_address], registered
//   rx_ring_wptr/rptr       write / read pointers (low ADDR_WIDTH bits)
//   usedw                   occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   registered status flags
//   overflow                sticky: a write was dropped
//   drop_cnt, underrun_cnt  saturating event counters
//   badhdr_cnt              invalid sync-header writes (optional)
//
// Build option
//   SONIC_RX_SYNC_HDR_CHECK_EN: only stores blocks whose sync header
//   data_in[1:0] is 2'b01 or 2'b10, and adds the badhdr_cnt output.
//   This option needs DATA_WIDTH >= 2.
`default_nettype none

module sonic_rx_ring_ctl #(
  parameter int DATA_WIDTH      = 66,
  parameter int ADDR_WIDTH      = 10,
  parameter int ALMOST_FULL_TH  = 2**ADDR_WIDTH - 16,
  parameter int ALMOST_EMPTY_TH = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wrena,
  input  logic                  wrreq,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  rdena,
  input  logic                  rdreq,
  input  logic                  clear_cnt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] rx_ring_wptr,
  output logic [ADDR_WIDTH-1:0] rx_ring_rptr,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
  output logic [CNT_WIDTH-1:0]  underrun_cnt,
  output logic [CNT_WIDTH-1:0]  badhdr_cnt
`else
  output logic [CNT_WIDTH-1:0]  underrun_cnt
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   usedw_next;

  logic wr_req, rd_req, hdr_ok;
  logic wr_acc, wr_drop, rd_acc, rd_under;

  assign wr_req = wrena & wrreq;
  assign rd_req = rdena & rdreq;

`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
  assign hdr_ok = (data_in[1:0] == 2'b01) || (data_in[1:0] == 2'b10);
`else
  assign hdr_ok = 1'b1;
`endif

  // full/empty are the registered flags, so a same-cycle release never
  // frees room for a write and a same-cycle write never feeds a release.
  assign wr_acc   = wr_req & ~full & hdr_ok;
  assign wr_drop  = wr_req & full;
  assign rd_acc   = rd_req & ~empty;
  assign rd_under = rd_req & empty;

  assign rx_ring_wptr = wptr[ADDR_WIDTH-1:0];
  assign rx_ring_rptr = rptr[ADDR_WIDTH-1:0];

  always_comb begin
    usedw_next = usedw;
    if (wr_acc && !rd_acc)
      usedw_next = usedw + PTR_ONE;
    else if (!wr_acc && rd_acc)
      usedw_next = usedw - PTR_ONE;
  end

  // Flags are registered from usedw_next so they always agree with usedw.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
      usedw        <= usedw_next;
      full         <= (usedw_next == DEPTH_W);
      empty        <= (usedw_next == '0);
      almost_full  <= (usedw_next >= AF_TH);
      almost_empty <= (usedw_next <= AE_TH);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      underrun_cnt <= '0;
    end else if (clear_cnt) begin
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      if (wr_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (rd_under && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
  logic hdr_bad;
  assign hdr_bad = wr_req & ~full & ~hdr_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      badhdr_cnt <= '0;
    else if (clear_cnt)
      badhdr_cnt <= '0;
    else if (hdr_bad && badhdr_cnt != '1)
      badhdr_cnt <= badhdr_cnt + 1'b1;
  end
`endif

  // Ring storage is not reset; non-blocking read returns old data when the
  // same slot is written in the same cycle.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      data_out <= '0;
    else
      data_out <= mem[rd_address];
  end

endmodule

`default_nettype wire

// File: tb/tb_sonic_rx_ring_ctl.sv
// Testbench for sonic_rx_ring_ctl. It runs with a 16-deep ring and a small
// counter width so that the counters can reach saturation.
`timescale 1ns/1ps

module tb_sonic_rx_ring_ctl;

  localparam int DW    = 66;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 3;
  localparam int CW    = 6;
  localparam int CMAX  = 63;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wrena = 1'b0, wrreq = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic          rdena = 1'b0, rdreq = 1'b0, clear_cnt = 1'b0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] rx_ring_wptr, rx_ring_rptr;
  logic [AW:0]   usedw;
  logic          full, empty, almost_full, almost_empty, overflow;
  logic [CW-1:0] drop_cnt, underrun_cnt;
`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
  logic [CW-1:0] badhdr_cnt;
`endif

  sonic_rx_ring_ctl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF),
    .ALMOST_EMPTY_TH(AE), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in),
    .wrena(wrena), .wrreq(wrreq), .rd_address(rd_address),
    .rdena(rdena), .rdreq(rdreq), .clear_cnt(clear_cnt),
    .data_out(data_out), .rx_ring_wptr(rx_ring_wptr),
    .rx_ring_rptr(rx_ring_rptr), .usedw(usedw), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .drop_cnt(drop_cnt),
`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
    .underrun_cnt(underrun_cnt), .badhdr_cnt(badhdr_cnt)
`else
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: the ring is a queue of stored blocks; the slot array
  // remembers what every slot holds (storage survives reset).
  logic [DW-1:0] q[$];
  logic [DW-1:0] mmem [DEPTH];
  bit            mvalid [DEPTH];
  int unsigned   mwp, mrp, mdrop, munder, mbad;
  bit            movf;
  logic [DW-1:0] mdout;
  bit            mdout_known;

  function automatic bit hdr_valid(input logic [DW-1:0] d);
`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
    logic [1:0] h;
    h = d[1:0];
    return (h == 2'b01) || (h == 2'b10);
`else
    return 1'b1;
`endif
  endfunction

  // Table data: under header checking, plain k would carry bad headers, so
  // k is shifted up and given a valid 01 header instead.
  function automatic logic [DW-1:0] td(input int unsigned k);
    logic [DW-1:0] v;
    v = DW'(k);
`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
    v = (v << 2) | DW'(1);
`endif
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    mwp = 0; mrp = 0; mdrop = 0; munder = 0; mbad = 0;
    movf = 1'b0; mdout = '0; mdout_known = 1'b1;
  endtask

  task automatic model_step();
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    mdout_known = mvalid[rd_address];
    mdout       = mmem[rd_address];
    if (wrena && wrreq) begin
      if (was_full) begin
        movf = 1'b1;
        if (mdrop < CMAX) mdrop++;
      end else if (hdr_valid(data_in)) begin
        mmem[mwp] = data_in;
        mvalid[mwp] = 1'b1;
        q.push_back(data_in);
        mwp = (mwp + 1) % DEPTH;
      end else if (mbad < CMAX) begin
        mbad++;
      end
    end
    if (rdena && rdreq) begin
      if (was_empty) begin
        if (munder < CMAX) munder++;
      end else begin
        void'(q.pop_front());
        mrp = (mrp + 1) % DEPTH;
      end
    end
    if (clear_cnt) begin
      mdrop = 0; munder = 0; mbad = 0; movf = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int unsigned n;
    n = q.size();
    chk("usedw", usedw, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= AF);
    chk("almost_empty", almost_empty, n <= AE);
    chk("wptr", rx_ring_wptr, mwp);
    chk("rptr", rx_ring_rptr, mrp);
    chk("overflow", overflow, movf);
    chk("drop_cnt", drop_cnt, mdrop);
    chk("underrun_cnt", underrun_cnt, munder);
`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
    chk("badhdr_cnt", badhdr_cnt, mbad);
`endif
    if (mdout_known) chk("data_out", data_out, mdout);
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, check at next negedge.
  task automatic cycle(input bit wen, input bit wrq, input logic [DW-1:0] din,
                       input logic [AW-1:0] ra, input bit ren, input bit rrq,
                       input bit clr);
    wrena = wen; wrreq = wrq; data_in = din; rd_address = ra;
    rdena = ren; rdreq = rrq; clear_cnt = clr;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic idle(input logic [AW-1:0] ra);
    cycle(1'b0, 1'b0, '0, ra, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    wrena = 1'b0; wrreq = 1'b0; rdena = 1'b0; rdreq = 1'b0; clear_cnt = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_usedw", usedw, 0);
    compare_outputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit            wr;
    bit            rel;
    logic [DW-1:0] din;
    logic [AW-1:0] raddr;
    int unsigned   e_usedw;
    int unsigned   e_rptr;
    bit            e_full;
    bit            e_empty;
    int unsigned   e_drop;
    bit            chk_dout;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit wr, bit rel, logic [DW-1:0] din, logic [AW-1:0] ra,
                              int unsigned u, int unsigned rp, bit f, bit e,
                              int unsigned dr, bit cd, logic [DW-1:0] dexp);
    vec_t v;
    v.wr = wr; v.rel = rel; v.din = din; v.raddr = ra; v.e_usedw = u;
    v.e_rptr = rp; v.e_full = f; v.e_empty = e; v.e_drop = dr;
    v.chk_dout = cd; v.e_dout = dexp;
    return v;
  endfunction

  initial begin
    logic [95:0] rnd;
    int unsigned pw;
    int unsigned wprob [6] = '{90, 10, 50, 97, 3, 50};

    for (int unsigned i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;

    // Fill, read-back, overflow and same-cycle release-vs-write from reset.
    for (int unsigned k = 1; k <= 5; k++)
      tbl.push_back(mk(1, 0, td(k), 0, k, 0, 0, 0, 0, k >= 2, td(1)));
    tbl.push_back(mk(0, 0, '0, 2, 5, 0, 0, 0, 0, 1, td(3)));
    for (int unsigned k = 6; k <= 16; k++)
      tbl.push_back(mk(1, 0, td(k), 0, k, 0, k == 16, 0, 0, 1, td(1)));
    for (int unsigned j = 1; j <= 3; j++)
      tbl.push_back(mk(1, 0, td(100 + j), 0, 16, 0, 1, 0, j, 1, td(1)));
    tbl.push_back(mk(0, 0, '0, 0, 16, 0, 1, 0, 3, 1, td(1)));
    tbl.push_back(mk(1, 1, td(200), 15, 15, 1, 0, 0, 4, 1, td(16)));

    @(negedge clock);
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].wr, tbl[i].wr, tbl[i].din, tbl[i].raddr, tbl[i].rel, tbl[i].rel, 1'b0);
      chk("tbl_usedw", usedw, tbl[i].e_usedw);
      chk("tbl_rptr", rx_ring_rptr, tbl[i].e_rptr);
      chk("tbl_full", full, tbl[i].e_full);
      chk("tbl_empty", empty, tbl[i].e_empty);
      chk("tbl_drop", drop_cnt, tbl[i].e_drop);
      if (tbl[i].chk_dout) chk("tbl_dout", data_out, tbl[i].e_dout);
    end
    chk("tbl_overflow", overflow, 1);

    // Wrap: 20 write/release pairs on a 16-deep ring.
    do_reset();
    for (int unsigned k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b1, td(300 + k), '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    end
    chk("wrap_wptr", rx_ring_wptr, 4);
    chk("wrap_rptr", rx_ring_rptr, 4);
    chk("wrap_usedw", usedw, 0);
    chk("wrap_empty", empty, 1);

    // Underrun while empty, then clear.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("under_cnt", underrun_cnt, 2);
    chk("under_rptr", rx_ring_rptr, 4);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("under_clear", underrun_cnt, 0);

    // Drop and clear in the same cycle: clear wins.
    for (int unsigned k = 0; k < DEPTH; k++)
      cycle(1'b1, 1'b1, td(400 + k), '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, td(499), '0, 1'b0, 1'b0, 1'b0);
    chk("drop_one", drop_cnt, 1);
    cycle(1'b1, 1'b1, td(498), '0, 1'b0, 1'b0, 1'b1);
    chk("drop_clear_wins", drop_cnt, 0);
    chk("ovf_clear_wins", overflow, 0);

    // Reset mid-stream, then first write lands in slot 0.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 1'b1, td(77), '0, 1'b0, 1'b0, 1'b0);
    idle('0);
    chk("post_reset_slot0", data_out, td(77));

`ifdef SONIC_RX_SYNC_HDR_CHECK_EN
    // Sync-header check: 00 and 11 rejected, 01 stored.
    begin
      int unsigned u0;
      u0 = usedw;
      cycle(1'b1, 1'b1, DW'(8), '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, DW'(11), '0, 1'b0, 1'b0, 1'b0);
      chk("hdr_bad_cnt", badhdr_cnt, 2);
      chk("hdr_usedw_hold", usedw, u0);
      cycle(1'b1, 1'b1, DW'(9), '0, 1'b0, 1'b0, 1'b0);
      chk("hdr_good_usedw", usedw, u0 + 1);
    end
`endif

    // Randomised traffic with write/release bias phases to reach full,
    // empty, watermarks and counter saturation.
    for (int unsigned ph = 0; ph < 6; ph++) begin
      pw = wprob[ph];
      for (int unsigned c = 0; c < 300; c++) begin
        rnd = {$urandom(), $urandom(), $urandom()};
        cycle(($urandom % 8) != 0, ($urandom % 100) < pw, rnd[DW-1:0],
              AW'($urandom), ($urandom % 8) != 0, ($urandom % 100) < (100 - pw),
              ($urandom % 200) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sonic_rx_ring_ctl.md
Name: sonic_rx_ring_ctl

Overview:
Parametrised single-clock RX ring buffer with built-in flow control for the SONIC receive path.
- Gearbox writes DATA_WIDTH-bit blocks in order.
- DMA reads any slot by address, then releases slots in order with rdreq.
- The block tracks occupancy, flags full/empty/watermarks, drops and counts writes on overflow, and exports the write pointer to the IRQ logic.
- Successor to the fixed 66-bit RX control block: adds parametrised width/depth, programmable watermarks, and overflow protection with drop counting.

Parameters:
DATA_WIDTH, 66, width of each stored block.
ADDR_WIDTH, 10, log2 of ring depth; DEPTH = 2**ADDR_WIDTH.
ALMOST_FULL_TH, 2**ADDR_WIDTH-16, almost_full asserts when usedw >= this value.
ALMOST_EMPTY_TH, 16, almost_empty asserts when usedw <= this value.
CNT_WIDTH, 16, width of the drop and underrun counters.

Ports:
clock  input  1  sole clock
reset_n  input  1  asynchronous active-low reset
data_in  input  DATA_WIDTH  block from gearbox
wrena  input  1  enable_sfp && xcvr_ready
wrreq  input  1  gearbox valid && block lock
rd_address  input  ADDR_WIDTH  DMA random-read slot
rdena  input  1  read-side enable
rdreq  input  1  release oldest slot (advance rptr)
clear_cnt  input  1  synchronous clear of counters and sticky flags
data_out  output  DATA_WIDTH  mem[rd_address], registered
rx_ring_wptr  output  ADDR_WIDTH  write pointer, exported to IRQ
rx_ring_rptr  output  ADDR_WIDTH  read pointer
usedw  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
full, empty, almost_full, almost_empty  output  1 each  status flags
overflow  output  1  sticky: a write was dropped
drop_cnt  output  CNT_WIDTH  dropped writes, saturating
underrun_cnt  output  CNT_WIDTH  releases attempted while empty, saturating

Behaviour:
Reset (reset_n low, asynchronous):
- Pointers, usedw, counters, overflow and data_out go to 0.
- empty=1, almost_empty=1, full=0, almost_full=0.
- Memory contents are not reset.
- Reset mid-operation discards all buffered data. The first accepted write after release lands in slot 0.

Pointers:
- Internal wptr and rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- Exported pointers are the low ADDR_WIDTH bits and wrap DEPTH-1 -> 0.

Write path:
- wr_acc = wrena && wrreq && !full.
- On wr_acc: mem[wptr] <= data_in, then wptr+1.
- If wrena && wrreq && full: data is not written, drop_cnt+1 (saturates at all-ones), overflow <= 1.

Release path:
- rd_acc = rdena && rdreq && !empty; on rd_acc, rptr+1.
- If rdena && rdreq && empty: rptr holds, underrun_cnt+1 (saturating).

Status flags:
- full and empty are evaluated from registered state only.
- A simultaneous release does not unblock a write in the same cycle; the write is dropped.
- A simultaneous write does not satisfy a release from empty in the same cycle.
- usedw <= usedw + wr_acc - rd_acc, i.e. equals wptr - rptr modulo 2**(ADDR_WIDTH+1).
- All flags are registered and consistent with usedw in the same cycle:
  - full = (usedw == DEPTH)
  - empty = (usedw == 0)
  - almost_full = (usedw >= ALMOST_FULL_TH)
  - almost_empty = (usedw <= ALMOST_EMPTY_TH)

Read data:
- data_out = mem[rd_address] one cycle after rd_address is presented.
- Independent of rdena and rdreq.
- Read-during-write to the same slot returns the old data.

Counter clear:
- clear_cnt zeroes drop_cnt, underrun_cnt and overflow next cycle.
- If a drop occurs in the same cycle, clear wins and the counter reads 0.

Optional Feature:
Macro SONIC_RX_SYNC_HDR_CHECK_EN.
- Defined:
  - data_in[1:0] is the 64b/66b sync header; only 2'b01 or 2'b10 is valid.
  - An otherwise-accepted write with an invalid header is not stored and pointers hold.
  - Each such write increments an added output badhdr_cnt[CNT_WIDTH-1:0] (saturating, reset 0, cleared by clear_cnt).
  - Requires DATA_WIDTH >= 2.
- Undefined: no header check and no badhdr_cnt port; all accepted writes are stored.

Test Plan:
1. Reset, then 5 writes (data_in = 1..5), rd_address=2 -> data_out=3 one cycle later; usedw=5, rx_ring_wptr=5, empty=0.
2. ADDR_WIDTH=4: 16 writes, then 3 more -> full=1, usedw=16, drop_cnt=3, overflow=1; slot 0 still holds the first word.
3. From full (usedw=16), write and rdreq in the same cycle -> write dropped, usedw=15, drop_cnt increments, rx_ring_rptr=1.
4. Wrap: 20 write/release pairs with ADDR_WIDTH=4 -> rx_ring_wptr=4, rx_ring_rptr=4, usedw=0, empty=1.
5. rdreq while empty, 2 cycles -> underrun_cnt=2, rptr unchanged; then clear_cnt -> underrun_cnt=0; reset_n low mid-stream -> usedw=0 immediately (asynchronously).
6. With SONIC_RX_SYNC_HDR_CHECK_EN defined: write data_in[1:0]=2'b00, then 2'b11 -> badhdr_cnt=2, usedw unchanged; write 2'b01 -> usedw+1.
